fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage for the hart once the combinational instruction memory is replaced by a variable-latency memory with a request/response handshake. It owns the fetch PC and issues word-aligned fetches, with at most one request outstanding. Returned words are buffered with their PCs in a DEPTH-entry in-order queue, and decode drains the queue through a valid/ready handshake. Branch/jump redirects from execute flush the queue and discard any in-flight response.

## Interface
- RESET_ADDR, 32'h00000000, fetch PC after reset.
- DEPTH, 2, instruction queue entries; power of two, at least 2.

- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- o_mem_req  out  1  fetch request valid.
- o_mem_addr  out  32  fetch address; bits [1:0] are always 0.
- i_mem_ready  in  1  memory accepts the request this cycle.
- i_mem_valid  in  1  response valid; in order, one per accepted request.
- i_mem_rdata  in  32  instruction word returned by memory.
- i_redirect  in  1  single-cycle pulse requesting a taken branch/jump.
- i_redirect_pc  in  32  redirect target.
- o_inst_valid  out  1  queue head is valid.
- o_inst  out  32  head instruction word.
- o_inst_pc  out  32  head PC.
- o_inst_trap  out  1  head is a misaligned-target trap entry.
- i_inst_ready  in  1  decode consumes the head.

## Operation
- State:
  - fetch PC, count (0..DEPTH);
  - outstanding flag and its request PC;
  - discard flag, trap_stall flag;
  - queue of {word, pc, trap} entries.
- Issue condition, with pop = o_inst_valid && i_inst_ready and resp = i_mem_valid && !discard:
  - o_mem_req = !trap_stall && !discard && !i_redirect && (!outstanding || resp) && (count - pop + outstanding < DEPTH).
  - o_mem_req may depend combinationally on i_inst_ready, i_mem_valid and i_redirect.
- o_mem_addr equals the fetch PC.
- Accept (o_mem_req && i_mem_ready):
  - fetch PC <= fetch PC + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000);
  - outstanding <= 1, request PC latched.
- Response while outstanding:
  - if !discard, push {i_mem_rdata, request PC, 0};
  - outstanding <= 0 unless a new request is accepted in the same cycle;
  - discard <= 0.
- i_mem_valid while not outstanding is ignored.
- Pop: on valid && ready, advance the head. Push and pop may occur in the same cycle.
- Redirect (i_redirect=1), which has priority over every other event that cycle:
  - queue flushed (count <= 0) and same-cycle push/pop dropped;
  - trap_stall <= 0; fetch PC <= i_redirect_pc;
  - if outstanding and no response this cycle: discard <= 1, and the next response is dropped;
  - if a response arrives the same cycle: it is dropped, outstanding <= 0, discard stays 0;
  - if i_redirect_pc[1:0] != 0: push trap entry {32'h0, i_redirect_pc, 1}, trap_stall <= 1, no fetches until the next redirect.
- Head outputs when empty: o_inst = 0, o_inst_pc = 0, o_inst_trap = 0.

## Timing
- Reset values (asynchronous):
  - o_mem_req 0, o_mem_addr RESET_ADDR;
  - o_inst_valid 0, o_inst 0, o_inst_pc 0, o_inst_trap 0;
  - all flags and count 0.
- First request on the first edge-free cycle after i_rst deasserts.
- Reset mid-operation drops the queue and the outstanding state. A response arriving after reset is ignored, since outstanding = 0.
- Memory returns the response no earlier than the cycle after acceptance.
- Fetch-to-decode latency: response cycle N → o_inst_valid in cycle N+1 (queue registered).
- Throughput: 1 instruction/cycle with i_mem_ready=1, response latency 1 and decode always ready.
- Queue full: no request is issued. Queue and in-flight occupancy never exceed DEPTH.
- o_mem_req may deassert without acceptance only on redirect or a change in the pop/response inputs.
- o_mem_addr changes only on accept, redirect or reset.

## Test plan
- Reset with RESET_ADDR=0x100, ready=1, latency 1, decode ready → o_inst_pc sequence 0x100, 0x104, 0x108 on consecutive cycles from cycle 2; o_inst equals memory contents.
- Decode ready held 0 for 6 cycles → exactly DEPTH=2 entries buffered, o_mem_req=0. Release ready → entries 0x100, 0x104 in order, no loss or duplicate.
- Latency-3 memory, redirect to 0x200 while 0x108 is in flight → 0x108 response dropped, next request 0x200, first delivered o_inst_pc=0x200.
- Redirect to 0x202 → one entry: o_inst_trap=1, o_inst_pc=0x202, no o_mem_req. A later redirect to 0x300 resumes fetch.
- Fetch PC at 0xFFFFFFFC → next o_mem_addr 0x00000000.
- i_rst asserted mid-flight with a response pending → outputs at reset values immediately. Stale i_mem_valid ignored; fetch restarts at RESET_ADDR.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage with a request/response memory port, one request
// in flight at most, and a small in-order queue feeding decode.
// Redirects flush the queue. Any response still in flight is dropped.
module fetch_stage #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ready,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_inst_trap,
    input  logic        i_inst_ready
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
        logic        trap;
    } entry_t;

    entry_t          q [DEPTH];
    logic [AW-1:0]   head, tail;
    logic [CW-1:0]   count;
    logic [31:0]     pc, req_pc;
    logic            outstanding, discard, trap_stall;

    logic            pop, rsp, push, accept, misaligned;
    logic [CW:0]     occ;

    assign o_inst_valid = (count != '0);
    assign pop          = o_inst_valid && i_inst_ready;
    // Any response while a request is outstanding retires it, kept or not.
    assign rsp          = i_mem_valid && outstanding;
    assign push         = rsp && !discard;
    assign misaligned   = |i_redirect_pc[1:0];

    // Queue entries plus the in-flight word after this cycle's pop; a push
    // retires the in-flight slot, so it does not change this sum.
    assign occ = {1'b0, count} - (CW+1)'(pop) + (CW+1)'(outstanding);

    // Request when there is room for the returning word and nothing blocks.
    always_comb begin
        o_mem_req = !i_rst && !trap_stall && !discard && !i_redirect &&
                    (!outstanding || push) && (occ < (CW+1)'(DEPTH));
    end

    assign accept     = o_mem_req && i_mem_ready;
    // A trap redirect may leave the PC misaligned, but no fetch issues then.
    assign o_mem_addr = {pc[31:2], 2'b00};

    // Head view is zeroed when the queue is empty.
    always_comb begin
        o_inst      = '0;
        o_inst_pc   = '0;
        o_inst_trap = 1'b0;
        if (o_inst_valid) begin
            o_inst      = q[head].word;
            o_inst_pc   = q[head].pc;
            o_inst_trap = q[head].trap;
        end
    end

    // Queue storage. A misaligned redirect places the trap entry at slot 0.
    always_ff @(posedge i_clk) begin
        if (i_redirect) begin
            if (misaligned)
                q[0] <= '{word: 32'h0, pc: i_redirect_pc, trap: 1'b1};
        end else if (push) begin
            q[tail] <= '{word: i_mem_rdata, pc: req_pc, trap: 1'b0};
        end
    end

    // PC, handshake flags and queue pointers. A redirect takes priority.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc          <= RESET_ADDR;
            req_pc      <= '0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            trap_stall  <= 1'b0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else if (i_redirect) begin
            pc          <= i_redirect_pc;
            trap_stall  <= misaligned;
            head        <= '0;
            tail        <= AW'(misaligned);
            count       <= CW'(misaligned);
            // A response in this cycle is the one we would have discarded.
            outstanding <= outstanding && !i_mem_valid;
            discard     <= outstanding && !i_mem_valid;
        end else begin
            if (accept) begin
                pc          <= pc + 32'd4;
                req_pc      <= pc;
                outstanding <= 1'b1;
            end else if (rsp) begin
                outstanding <= 1'b0;
            end
            if (rsp)
                discard <= 1'b0;
            if (push)
                tail <= tail + AW'(1);
            if (pop)
                head <= head + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a variable-latency memory responder,
// a scoreboard of expected {pc, word, trap} entries checked on every
// decode pop, and a linear sequence of scenarios.
module tb_fetch_stage;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_ready = 1'b1;
    logic        i_mem_valid = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        o_inst_trap;
    logic        i_inst_ready = 1'b1;

    fetch_stage #(.RESET_ADDR(32'h100), .DEPTH(2)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
        .i_mem_ready(i_mem_ready), .i_mem_valid(i_mem_valid),
        .i_mem_rdata(i_mem_rdata),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_inst_valid(o_inst_valid), .o_inst(o_inst),
        .o_inst_pc(o_inst_pc), .o_inst_trap(o_inst_trap),
        .i_inst_ready(i_inst_ready)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { logic [31:0] pc; logic [31:0] word; logic trap; } exp_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;

    exp_t  exp_q[$];
    pend_t pend_q[$];
    int    errors = 0, checks = 0;
    int    lat = 1, cyc = 0, pops = 0, accepts = 0;

    function automatic logic [31:0] mword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory responder and scoreboard checker.
    initial begin
        pend_t p;
        exp_t  e;
        forever begin
            @(negedge i_clk);
            if (!i_rst && o_mem_req && i_mem_ready) begin
                pend_q.push_back('{o_mem_addr, cyc + lat});
                accepts++;
            end
            if (!i_rst && o_inst_valid && i_inst_ready && !i_redirect) begin
                chk("sb_avail", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_pc",   o_inst_pc, e.pc);
                    chk("sb_word", o_inst, e.word);
                    chk("sb_trap", 32'(o_inst_trap), 32'(e.trap));
                end
                pops++;
            end
            @(posedge i_clk);
            #1;
            cyc++;
            i_mem_valid = 1'b0;
            if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
                p = pend_q.pop_front();
                i_mem_valid = 1'b1;
                i_mem_rdata = mword(p.addr);
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = start + 32'(4 * i);
            exp_q.push_back('{a, mword(a), 1'b0});
        end
    endtask

    task automatic wait_accept(input string tag);
        logic found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge i_clk);
            if (o_mem_req && i_mem_ready) found = 1'b1;
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_req_addr(input string tag, input logic [31:0] addr);
        logic found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge i_clk);
            if (o_mem_req) found = 1'b1;
        end
        chk({tag, "_seen"}, 32'(found), 32'd1);
        chk(tag, o_mem_addr, addr);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   32'(o_mem_req), 32'd0);
        chk({tag, "_addr"},  o_mem_addr, 32'h100);
        chk({tag, "_valid"}, 32'(o_inst_valid), 32'd0);
        chk({tag, "_inst"},  o_inst, 32'd0);
        chk({tag, "_pc"},    o_inst_pc, 32'd0);
        chk({tag, "_trap"},  32'(o_inst_trap), 32'd0);
    endtask

    // Directed scenarios.
    initial begin
        int          p0, a0;
        logic        found;

        // Reset values while reset is held.
        repeat (2) @(negedge i_clk);
        chk_reset_outputs("rst");

        // Streaming from RESET_ADDR, latency 1, decode always ready.
        push_seq(32'h100, 64);
        @(posedge i_clk); #1 i_rst = 1'b0;
        @(negedge i_clk);
        chk("c0_req",  32'(o_mem_req), 32'd1);
        chk("c0_addr", o_mem_addr, 32'h100);
        @(negedge i_clk);
        chk("c1_valid", 32'(o_inst_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            chk("stream_valid", 32'(o_inst_valid), 32'd1);
            chk("stream_pc", o_inst_pc, 32'h100 + 32'(4 * k));
        end

        // Decode stalls: queue fills and fetch stops.
        tick(); i_inst_ready = 1'b0;
        repeat (3) @(negedge i_clk);
        #1 a0 = accepts;
        repeat (3) @(negedge i_clk);
        #1;
        chk("stall_no_fetch", 32'(accepts), 32'(a0));
        chk("stall_req",   32'(o_mem_req), 32'd0);
        chk("stall_valid", 32'(o_inst_valid), 32'd1);
        tick(); i_inst_ready = 1'b1;
        p0 = pops;
        repeat (8) tick();
        chk("stall_release_pops", 32'(pops - p0 >= 6), 32'd1);

        // Latency 3, redirect with a request in flight.
        lat = 3;
        repeat (8) tick();
        wait_accept("redir_inflight");
        tick();
        i_redirect = 1'b1; i_redirect_pc = 32'h200;
        exp_q.delete(); push_seq(32'h200, 64);
        @(negedge i_clk);
        chk("redir_req_blocked", 32'(o_mem_req), 32'd0);
        tick(); i_redirect = 1'b0;
        wait_req_addr("redir_next_addr", 32'h200);
        p0 = pops;
        repeat (20) tick();
        chk("redir_pops", 32'(pops - p0 >= 3), 32'd1);

        // Misaligned redirect: single trap entry, fetch stalls.
        lat = 1;
        tick();
        i_inst_ready = 1'b0;
        i_redirect = 1'b1; i_redirect_pc = 32'h202;
        exp_q.delete(); exp_q.push_back('{32'h202, 32'h0, 1'b1});
        tick(); i_redirect = 1'b0;
        @(negedge i_clk);
        chk("trap_valid", 32'(o_inst_valid), 32'd1);
        chk("trap_flag",  32'(o_inst_trap), 32'd1);
        chk("trap_pc",    o_inst_pc, 32'h202);
        chk("trap_inst",  o_inst, 32'h0);
        chk("trap_req",   32'(o_mem_req), 32'd0);
        repeat (3) @(negedge i_clk);
        chk("trap_hold_req", 32'(o_mem_req), 32'd0);
        tick(); i_inst_ready = 1'b1;
        tick();
        @(negedge i_clk);
        chk("trap_empty_valid", 32'(o_inst_valid), 32'd0);
        chk("trap_empty_inst",  o_inst, 32'd0);
        chk("trap_empty_pc",    o_inst_pc, 32'd0);
        chk("trap_empty_trap",  32'(o_inst_trap), 32'd0);
        chk("trap_empty_req",   32'(o_mem_req), 32'd0);
        tick();
        i_redirect = 1'b1; i_redirect_pc = 32'h300;
        exp_q.delete(); push_seq(32'h300, 64);
        tick(); i_redirect = 1'b0;
        wait_req_addr("resume_addr", 32'h300);
        repeat (10) tick();

        // PC wrap at the top of the address space.
        i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFF8;
        exp_q.delete(); push_seq(32'hFFFF_FFF8, 64);
        tick(); i_redirect = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge i_clk);
            if (o_mem_req && o_mem_addr == 32'hFFFF_FFFC) found = 1'b1;
        end
        chk("wrap_top_seen", 32'(found), 32'd1);
        wait_req_addr("wrap_addr", 32'h0);
        p0 = pops;
        repeat (8) tick();
        chk("wrap_pops", 32'(pops - p0 >= 5), 32'd1);

        // Asynchronous reset with a response still pending.
        lat = 3;
        tick();
        wait_accept("rst_inflight");
        tick();
        #2 i_rst = 1'b1;
        #1 chk_reset_outputs("midrst");
        i_mem_ready = 1'b0;
        exp_q.delete(); push_seq(32'h100, 64);
        @(posedge i_clk); #1 i_rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge i_clk);
            if (pend_q.size() == 0 && !i_mem_valid) found = 1'b1;
        end
        chk("stale_delivered", 32'(found), 32'd1);
        chk("stale_ignored", 32'(o_inst_valid), 32'd0);
        chk("restart_addr",  o_mem_addr, 32'h100);
        tick();
        lat = 1; i_mem_ready = 1'b1;
        p0 = pops;
        repeat (10) tick();
        chk("restart_pops", 32'(pops - p0 >= 5), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
